// File: rtl/alu_exec_pkg.sv
// Shared types for the EX-stage ALU: op codes, FSM states and op-class helpers.
package alu_exec_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OpAnd     = 4'b0000,
    OpOr      = 4'b0001,
    OpAdd     = 4'b0010,
    OpSub     = 4'b0011,
    OpXor     = 4'b0100,
    OpSll     = 4'b0101,
    OpSrl     = 4'b0110,
    OpSlt     = 4'b0111,
    OpBeq     = 4'b1000,
    OpSra     = 4'b1001,
    OpBne     = 4'b1010,
    OpBlt     = 4'b1011,
    OpBge     = 4'b1100,
    OpJal     = 4'b1101,
    OpIllegal = 4'b1110,
    OpJalr    = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StResp
  } exec_state_e;

  function automatic logic is_shift_op(alu_op_e op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Valid/ready request and response bundle between the ALU control decoder, the EX stage and EX/MEM.
interface alu_exec_if
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   operation;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              branch_taken;
  logic              illegal_op;

  modport master (
    output in_valid, operation, src_a, src_b, flush, out_ready,
    input  in_ready, out_valid, result, branch_taken, illegal_op
  );

  modport slave (
    input  in_valid, operation, src_a, src_b, flush, out_ready,
    output in_ready, out_valid, result, branch_taken, illegal_op
  );
endinterface

// File: rtl/alu_serial_shifter.sv
// Iterative shifter: load a value and amount, then each step shifts by min(SHIFT_STEP, remaining).
// value_o/done_o describe the step taken this cycle, so the caller can capture the final value directly.
module alu_serial_shifter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic [DATA_W-1:0]         value_i,
  input  logic [$clog2(DATA_W)-1:0] amount_i,
  input  logic                      dir_right_i,
  input  logic                      arith_i,
  input  logic                      step_i,
  output logic [DATA_W-1:0]         value_o,
  output logic                      done_o
);

  // One extra bit so SHIFT_STEP == DATA_W is representable.
  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0]        value_q;
  logic [CntW-1:0]          remaining_q;
  logic                     dir_right_q;
  logic                     arith_q;
  logic [CntW-1:0]          step_amt;
  logic signed [DATA_W-1:0] value_s;

  assign done_o   = remaining_q <= CntW'(SHIFT_STEP);
  assign step_amt = done_o ? remaining_q : CntW'(SHIFT_STEP);
  assign value_s  = value_q;

  always_comb begin
    value_o = value_q;
    if (!dir_right_q) begin
      value_o = value_q << step_amt;
    end else if (arith_q) begin
      value_o = value_s >>> step_amt;
    end else begin
      value_o = value_q >> step_amt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q     <= '0;
      remaining_q <= '0;
      dir_right_q <= 1'b0;
      arith_q     <= 1'b0;
    end else if (load_i) begin
      value_q     <= value_i;
      remaining_q <= {1'b0, amount_i};
      dir_right_q <= dir_right_i;
      arith_q     <= arith_i;
    end else if (step_i) begin
      value_q     <= value_o;
      remaining_q <= remaining_q - step_amt;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// EX-stage ALU with registered, handshaked result. Shifts are iterative unless
// ALU_EXEC_BARREL_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  alu_exec_if.slave bus_io
);

  localparam int unsigned ShW = $clog2(DATA_W);

  exec_state_e       state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              taken_q, taken_d;
  logic              illegal_q, illegal_d;

  alu_op_e           op;
  logic [DATA_W-1:0] a, b;
  logic [ShW-1:0]    shamt;
  logic              in_ready, accept, start, start_iter;
  logic [DATA_W-1:0] alu_res;
  logic              alu_taken, alu_illegal, cond;
  logic              sh_load, sh_step, sh_done;
  logic [DATA_W-1:0] sh_value;

  assign op     = alu_op_e'(bus_io.operation);
  assign a      = bus_io.src_a;
  assign b      = bus_io.src_b;
  assign shamt  = b[ShW-1:0];

  assign in_ready = !bus_io.flush &&
                    (state_q == StIdle || (state_q == StResp && bus_io.out_ready));
  assign accept   = bus_io.in_valid && in_ready;

  always_comb begin
    alu_res     = '0;
    alu_taken   = 1'b0;
    alu_illegal = 1'b0;
    cond        = 1'b0;
    case (op)
      OpAnd: alu_res = a & b;
      OpOr:  alu_res = a | b;
      OpAdd: alu_res = a + b;
      OpSub: alu_res = a - b;
      OpXor: alu_res = a ^ b;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      OpSll: alu_res = a << shamt;
      OpSrl: alu_res = a >> shamt;
      OpSra: alu_res = $signed(a) >>> shamt;
`else
      // Only reached for shamt == 0; non-zero amounts go through the serial shifter.
      OpSll, OpSrl, OpSra: alu_res = a;
`endif
      OpSlt: alu_res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OpBeq, OpBne, OpBlt, OpBge: begin
        unique case (op)
          OpBeq:   cond = (a == b);
          OpBne:   cond = (a != b);
          OpBlt:   cond = ($signed(a) < $signed(b));
          default: cond = ($signed(a) >= $signed(b));
        endcase
        alu_res   = {{(DATA_W-1){1'b0}}, cond};
        alu_taken = cond;
      end
      OpJal, OpJalr: begin
        alu_res   = a + b;
        alu_taken = 1'b1;
      end
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  assign start_iter = 1'b0;
  assign sh_value   = '0;
  assign sh_done    = 1'b1;
`else
  assign start_iter = is_shift_op(op) && (shamt != '0);

  alu_serial_shifter #(
    .DATA_W    (DATA_W),
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (sh_load),
    .value_i    (a),
    .amount_i   (shamt),
    .dir_right_i(op != OpSll),
    .arith_i    (op == OpSra),
    .step_i     (sh_step),
    .value_o    (sh_value),
    .done_o     (sh_done)
  );
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    sh_load   = 1'b0;
    sh_step   = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      StIdle: start = accept;
      StShift: begin
        sh_step = 1'b1;
        if (sh_done) begin
          state_d   = StResp;
          result_d  = sh_value;
          taken_d   = 1'b0;
          illegal_d = 1'b0;
        end
      end
      StResp: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
          start   = accept;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      if (start_iter) begin
        sh_load = 1'b1;
        state_d = StShift;
      end else begin
        state_d   = StResp;
        result_d  = alu_res;
        taken_d   = alu_taken;
        illegal_d = alu_illegal;
      end
    end
    // Flush kills whatever is in flight; in_ready is already low so nothing is accepted.
    if (bus_io.flush) begin
      state_d = StIdle;
      sh_step = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus_io.in_ready     = in_ready;
  assign bus_io.out_valid    = (state_q == StResp);
  assign bus_io.result       = result_q;
  assign bus_io.branch_taken = taken_q;
  assign bus_io.illegal_op   = illegal_q;

endmodule
